uart16550_tx: RTL and testbench

- Transmit path of the UART16550.
- Accepts bytes pushed by the register block on THR writes and buffers them in a TX FIFO (or a single THR when FIFOs are disabled).
- Serializes each byte onto sout_o using the 16x baud enable and the LCR framing settings.
- Returns the THR-empty and shift-register-empty status that the register block encodes into LSR.THRE/TEMT.

---
 rtl/uart16550_tx.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_uart16550_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart16550_tx.sv
// uart16550_tx: TX FIFO (or single THR) and frame serializer of the 16550 transmit path.
// Latency: a push into an empty FIFO in IDLE loads the shifter next cycle; sout_o adds one register stage.
// Backpressure: none on push, so bytes pushed while full are dropped. `UART16550_TX_AUTO_CTS_EN adds CTS gating of frame start.
module uart16550_tx #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       baud_en_i,
  input  logic       tx_push_i,
  input  logic [7:0] d_i,
  input  logic       fifo_ena_i,
  input  logic       tx_rst_i,
  input  logic [1:0] wls_i,
  input  logic       stb_i,
  input  logic       pen_i,
  input  logic       eps_i,
  input  logic       sp_i,
  input  logic       bc_i,
`ifdef UART16550_TX_AUTO_CTS_EN
  input  logic       cts_ni,
  input  logic       afe_i,
`endif
  output logic       sout_o,
  output logic       tx_empty_o,
  output logic       tx_sr_empty_o,
  output logic       tx_full_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------
  // FIFO storage and occupancy
  // ---------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] cap;
  logic             fifo_ena_q;
  logic             flush;
  logic             push_ok;
  logic             pop;
  logic             can_pop;
  logic             cts_ok;
  logic             empty_q;
  logic             full_q;
  logic [7:0]       head;

  // Without FIFOs only the THR slot is usable.
  assign cap     = fifo_ena_i ? DEPTH_C : CNT_W'(1);
  // Any change of FCR.ena discards queued bytes, exactly like FCR.tx_rst.
  assign flush   = tx_rst_i | (fifo_ena_i ^ fifo_ena_q);
  assign push_ok = tx_push_i & ~flush & (count_q < cap);
  assign can_pop = (count_q != '0) & ~flush & cts_ok;
  assign head    = mem[rd_ptr_q];

  // Occupancy update: flush wins, a simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers, count and registered status flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_ena_q <= fifo_ena_i;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      fifo_ena_q <= fifo_ena_i;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == cap);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Byte storage, written only on accepted pushes.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= d_i;
  end

  // ---------------------------------------------------------------
  // Auto flow control: CTS gates the start of a new frame only
  // ---------------------------------------------------------------
`ifdef UART16550_TX_AUTO_CTS_EN
  logic cts_s1_q;
  logic cts_s2_q;

  // Two-flop synchronizer; resets to "not clear to send".
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= cts_ni;
      cts_s2_q <= cts_s1_q;
    end
  end

  assign cts_ok = ~(afe_i & cts_s2_q);
`else
  assign cts_ok = 1'b1;
`endif

  // ---------------------------------------------------------------
  // Frame configuration captured at load (LCR writes mid-frame only
  // affect the next frame)
  // ---------------------------------------------------------------
  logic [7:0] data_mask;
  logic       par_load;
  logic [4:0] stop_last_load;
  logic [1:0] cfg_wls_q;
  logic       cfg_pen_q;
  logic       cfg_par_q;
  logic [4:0] cfg_stop_last_q;
  logic [2:0] last_bit;

  // Parity and stop length derived from the byte being loaded.
  always_comb begin
    data_mask = 8'hFF;
    case (wls_i)
      2'd0:    data_mask = 8'h1F;
      2'd1:    data_mask = 8'h3F;
      2'd2:    data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
    par_load       = sp_i ? ~eps_i : ((^(head & data_mask)) ^ ~eps_i);
    stop_last_load = stb_i ? ((wls_i == 2'd0) ? 5'd23 : 5'd31) : 5'd15;
  end

  assign last_bit = 3'd4 + {1'b0, cfg_wls_q};

  // ---------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [4:0] tick_q;
  logic [4:0] tick_d;
  logic [2:0] bit_q;
  logic [2:0] bit_d;
  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic       load;
  logic       sout_d;
  logic       bit_done;
  logic       sout_q;
  logic       sr_empty_q;

  assign bit_done = baud_en_i & (tick_q == 5'd15);

  // Next-state, shifter and serial-bit selection.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load    = 1'b0;
    sout_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (can_pop) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        sout_d = 1'b0;
        if (bit_done) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else if (baud_en_i) begin
          tick_d = tick_q + 5'd1;
        end
      end
      DATA: begin
        sout_d = shift_q[0];
        if (bit_done) begin
          tick_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == last_bit) begin
            state_d = cfg_pen_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else if (baud_en_i) begin
          tick_d = tick_q + 5'd1;
        end
      end
      PARITY: begin
        sout_d = cfg_par_q;
        if (bit_done) begin
          tick_d  = '0;
          state_d = STOP;
        end else if (baud_en_i) begin
          tick_d = tick_q + 5'd1;
        end
      end
      STOP: begin
        sout_d = 1'b1;
        if (baud_en_i) begin
          if (tick_q == cfg_stop_last_q) begin
            tick_d = '0;
            // Chain straight into the next frame when data is waiting.
            if (can_pop) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      tick_d  = '0;
      bit_d   = '0;
      shift_d = head;
    end
    // Break overrides the line but leaves the FSM running.
    if (bc_i) sout_d = 1'b0;
  end

  assign pop = load;

  // FSM state, counters, latched frame config and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      tick_q          <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      cfg_wls_q       <= '0;
      cfg_pen_q       <= 1'b0;
      cfg_par_q       <= 1'b0;
      cfg_stop_last_q <= 5'd15;
      sout_q          <= 1'b1;
      sr_empty_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      sout_q     <= sout_d;
      sr_empty_q <= (state_d == IDLE);
      if (load) begin
        cfg_wls_q       <= wls_i;
        cfg_pen_q       <= pen_i;
        cfg_par_q       <= par_load;
        cfg_stop_last_q <= stop_last_load;
      end
    end
  end

  assign sout_o        = sout_q;
  assign tx_empty_o    = empty_q;
  assign tx_full_o     = full_q;
  assign tx_sr_empty_o = sr_empty_q;

endmodule

// File: tb/tb_uart16550_tx.sv
// tb_uart16550_tx: directed stimulus with a frame scoreboard for uart16550_tx.
// Stimulus pushes expected frames; a monitor decodes sout_o on baud pulses and compares.
// Timing and flag checks run in the main sequence against hand-computed windows.
module tb_uart16550_tx;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       baud_en = 1'b0;
  logic       tx_push = 1'b0;
  logic [7:0] d = 8'h00;
  logic       fifo_ena = 1'b0;
  logic       tx_rst = 1'b0;
  logic [1:0] wls = 2'd3;
  logic       stb = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sp = 1'b0;
  logic       bc = 1'b0;
  logic       sout_o;
  logic       tx_empty_o;
  logic       tx_sr_empty_o;
  logic       tx_full_o;
`ifdef UART16550_TX_AUTO_CTS_EN
  logic       cts_n = 1'b0;
  logic       afe = 1'b0;
`endif

  uart16550_tx #(.FIFO_DEPTH(16)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .baud_en_i     (baud_en),
    .tx_push_i     (tx_push),
    .d_i           (d),
    .fifo_ena_i    (fifo_ena),
    .tx_rst_i      (tx_rst),
    .wls_i         (wls),
    .stb_i         (stb),
    .pen_i         (pen),
    .eps_i         (eps),
    .sp_i          (sp),
    .bc_i          (bc),
`ifdef UART16550_TX_AUTO_CTS_EN
    .cts_ni        (cts_n),
    .afe_i         (afe),
`endif
    .sout_o        (sout_o),
    .tx_empty_o    (tx_empty_o),
    .tx_sr_empty_o (tx_sr_empty_o),
    .tx_full_o     (tx_full_o)
  );

  typedef struct {
    logic [7:0] data;
    int         nbits;
    bit         has_par;
    bit         par;
  } frame_t;

  frame_t exp_q[$];
  int     falls[$];
  int     n_checks = 0;
  int     n_pass = 0;
  int     cyc = 0;
  int     bdiv = 0;
  bit     baud_on = 1'b1;
  bit     mon_en = 1'b1;

  initial forever #5 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // 16x baud enable: one pulse every 4 clocks while baud_on is set.
  initial forever begin
    @(posedge clk_i);
    #1;
    baud_en = baud_on && (bdiv == 3);
    bdiv = (bdiv + 1) % 4;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic wait_pulses(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk_i);
      if (baud_en) k++;
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input int nb, input bit hp, input bit p);
    frame_t f;
    f.data = b; f.nbits = nb; f.has_par = hp; f.par = p;
    exp_q.push_back(f);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk_i); #1;
    tx_push = 1'b1;
    d = b;
    @(posedge clk_i); #1;
    tx_push = 1'b0;
  endtask

  // Waits for FIFO empty and shifter idle; returns the cycle or -1 on timeout.
  task automatic wait_idle(input string name, input int bound, output int at);
    int n = 0;
    at = -1;
    while (n < bound && at < 0) begin
      @(negedge clk_i);
      if (tx_sr_empty_o && tx_empty_o) at = cyc;
      n++;
    end
    chk(name, int'(at >= 0), 1);
  endtask

  // Monitor: on each start edge pop the scoreboard and decode mid-bit samples.
  initial begin : monitor
    logic       prev;
    logic [7:0] rx;
    frame_t     e;
    prev = 1'b1;
    forever begin
      @(negedge clk_i);
      if (mon_en && prev && !sout_o) begin
        falls.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, expected none", cyc);
          wait_pulses(16 * 12);
        end else begin
          e = exp_q.pop_front();
          wait_pulses(8);
          chk("start_bit", sout_o, 0);
          rx = '0;
          for (int i = 0; i < e.nbits; i++) begin
            wait_pulses(16);
            rx[i] = sout_o;
          end
          chk("data_bits", rx, e.data);
          if (e.has_par) begin
            wait_pulses(16);
            chk("parity_bit", sout_o, e.par);
          end
          wait_pulses(16);
          chk("stop_bit", sout_o, 1);
        end
        prev = 1'b1;
      end else begin
        prev = sout_o;
      end
    end
  end

  initial begin : main
    int t_idle;
    int bad;
    logic held;

    repeat (5) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_sout", sout_o, 1);
    chk("rst_tx_empty", tx_empty_o, 1);
    chk("rst_sr_empty", tx_sr_empty_o, 1);
    chk("rst_tx_full", tx_full_o, 0);

    // 8N1, THR mode: 0x55
    expect_frame(8'h55, 8, 0, 0);
    push_byte(8'h55);
    @(negedge clk_i);
    chk("thr_full_after_push", tx_full_o, 1);
    chk("thr_nonempty_after_push", tx_empty_o, 0);
    @(negedge clk_i);
    chk("thr_empty_after_pop", tx_empty_o, 1);
    chk("thr_full_after_pop", tx_full_o, 0);
    chk("sr_busy_after_load", tx_sr_empty_o, 0);
    wait_idle("idle_8n1", 2000, t_idle);
    chk_range("frame_len_8n1", t_idle - falls[$], 630, 645);

    // 5 bits, even parity, 1.5 stop: 0x13 -> 1,1,0,0,1 parity 1
    wls = 2'd0; pen = 1'b1; eps = 1'b1; stb = 1'b1; sp = 1'b0;
    expect_frame(8'h13, 5, 1, 1);
    push_byte(8'h13);
    repeat (3) @(negedge clk_i);
    wait_idle("idle_5e15", 2000, t_idle);
    chk_range("frame_len_5e15", t_idle - falls[$], 535, 548);

    // Stick parity with eps=1 forces a 0 parity bit
    sp = 1'b1;
    expect_frame(8'h13, 5, 1, 0);
    push_byte(8'h13);
    repeat (3) @(negedge clk_i);
    wait_idle("idle_stick", 2000, t_idle);
    chk_range("frame_len_stick", t_idle - falls[$], 535, 548);

    // FIFO mode, 18 back-to-back pushes: 17 fit, the last is dropped
    wls = 2'd3; pen = 1'b0; eps = 1'b0; stb = 1'b0; sp = 1'b0;
    fifo_ena = 1'b1;
    repeat (3) @(negedge clk_i);
    falls.delete();
    for (int i = 0; i < 18; i++) begin
      @(posedge clk_i); #1;
      tx_push = 1'b1;
      d = 8'(i);
      if (i <= 16) expect_frame(8'(i), 8, 0, 0);
      @(negedge clk_i);
      if (i == 16) chk("full_after_16_pushes", tx_full_o, 0);
      if (i == 17) chk("full_after_17_pushes", tx_full_o, 1);
    end
    @(posedge clk_i); #1;
    tx_push = 1'b0;
    @(negedge clk_i);
    chk("full_after_drop", tx_full_o, 1);
    wait_idle("idle_burst", 14000, t_idle);
    chk("burst_frame_count", falls.size(), 17);
    bad = 0;
    for (int i = 1; i < falls.size(); i++)
      if (falls[i] - falls[i-1] < 636 || falls[i] - falls[i-1] > 640) bad++;
    chk("burst_gap_violations", bad, 0);

    // tx_rst and LCR change mid-frame: current 8-bit frame completes, queue dropped
    expect_frame(8'hC3, 8, 0, 0);
    @(posedge clk_i); #1;
    tx_push = 1'b1; d = 8'hC3;
    @(posedge clk_i); #1; d = 8'h3C;
    @(posedge clk_i); #1; d = 8'h5A;
    @(posedge clk_i); #1; tx_push = 1'b0;
    repeat (150) @(negedge clk_i);
    chk("queued_before_rst", tx_empty_o, 0);
    @(posedge clk_i); #1;
    tx_rst = 1'b1; wls = 2'd0;
    @(posedge clk_i); #1;
    tx_rst = 1'b0;
    @(negedge clk_i);
    chk("empty_after_tx_rst", tx_empty_o, 1);
    chk("frame_kept_after_tx_rst", tx_sr_empty_o, 0);
    wait_idle("idle_tx_rst", 2000, t_idle);
    chk_range("frame_len_after_rst", t_idle - falls[$], 630, 645);
    wls = 2'd3;

    // Break: line forced low with one cycle latency, FSM keeps draining
    mon_en = 1'b0;
    push_byte(8'hFF);
    repeat (150) @(negedge clk_i);
    @(posedge clk_i); #1;
    bc = 1'b1;
    @(negedge clk_i);
    chk("break_latency", sout_o, 1);
    @(negedge clk_i);
    chk("break_low", sout_o, 0);
    wait_idle("idle_break", 2000, t_idle);
    chk("break_held_in_idle", sout_o, 0);
    @(posedge clk_i); #1;
    bc = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("break_release", sout_o, 1);
    mon_en = 1'b1;
    repeat (4) @(negedge clk_i);

    // baud_en stalled: FSM holds its bit, FIFO still accepts
    expect_frame(8'h0F, 8, 0, 0);
    expect_frame(8'hF0, 8, 0, 0);
    push_byte(8'h0F);
    repeat (200) @(negedge clk_i);
    baud_on = 1'b0;
    repeat (6) @(negedge clk_i);
    held = sout_o;
    push_byte(8'hF0);
    @(negedge clk_i);
    chk("push_during_stall", tx_empty_o, 0);
    repeat (300) @(negedge clk_i);
    chk("sout_frozen_in_stall", sout_o, held);
    chk("sr_busy_in_stall", tx_sr_empty_o, 0);
    baud_on = 1'b1;
    wait_idle("idle_after_stall", 3000, t_idle);

`ifdef UART16550_TX_AUTO_CTS_EN
    // Auto-CTS: held off while CTS deasserted, starts once asserted
    afe = 1'b1; cts_n = 1'b1;
    repeat (4) @(negedge clk_i);
    expect_frame(8'hA5, 8, 0, 0);
    push_byte(8'hA5);
    repeat (100) @(negedge clk_i);
    chk("cts_hold_sout", sout_o, 1);
    chk("cts_hold_sr_empty", tx_sr_empty_o, 1);
    cts_n = 1'b0;
    wait_idle("idle_cts", 2000, t_idle);
    afe = 1'b0;
`endif

    repeat (20) @(negedge clk_i);
    chk("all_frames_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
